// File: rtl/sccb_reg_sequencer.sv
// Register-level sequencer above sccb_controller: expands one register write/read
// request into the START/WRITE/READ/STOP command stream and returns the result.
module sccb_reg_sequencer #(
    parameter logic [7:0] DEV_ID     = 8'h42,
    parameter int         GAP_CYCLES = 16,
    parameter int         BUSY_TO    = 15
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       sccb_flag,
    output logic [3:0] sccb_cmd,
    output logic [7:0] sccb_dat,
    input  logic       sccb_busy,
    input  logic [7:0] sccb_out_dat,
    input  logic       sccb_out_flag
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_NEXT, S_GAP, S_DONE
    } state_t;

    localparam logic [3:0] CMD_IDLE  = 4'b0000;
    localparam logic [3:0] CMD_START = 4'b0001;
    localparam logic [3:0] CMD_WRITE = 4'b0010;
    localparam logic [3:0] CMD_READ  = 4'b0011;
    localparam logic [3:0] CMD_STOP  = 4'b0110;

    // Read program: step 3 is the mid-program STOP, step 4 is the gap, step 7 the READ.
    localparam logic [3:0] RD_MID_STOP  = 4'd3;
    localparam logic [3:0] RD_RESTART   = 4'd5;
    localparam logic [3:0] RD_READ_STEP = 4'd7;

    localparam logic [7:0]  TO_LAST  = 8'(BUSY_TO - 1);
    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic        write_q, write_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        captured_q, captured_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [7:0]  dat_q, dat_d;
    logic        ready_q, ready_d;

    function automatic logic [11:0] step_word(input logic wr, input logic [3:0] step,
                                              input logic [7:0] addr, input logic [7:0] wdata);
        logic [11:0] w;
        w = {CMD_STOP, 8'h00};
        if (wr) begin
            case (step)
                4'd0:    w = {CMD_START, 8'h00};
                4'd1:    w = {CMD_WRITE, DEV_ID};
                4'd2:    w = {CMD_WRITE, addr};
                4'd3:    w = {CMD_WRITE, wdata};
                default: w = {CMD_STOP, 8'h00};
            endcase
        end else begin
            case (step)
                4'd0:    w = {CMD_START, 8'h00};
                4'd1:    w = {CMD_WRITE, DEV_ID};
                4'd2:    w = {CMD_WRITE, addr};
                4'd5:    w = {CMD_START, 8'h00};
                4'd6:    w = {CMD_WRITE, DEV_ID | 8'h01};
                4'd7:    w = {CMD_READ, 8'h00};
                default: w = {CMD_STOP, 8'h00};
            endcase
        end
        return w;
    endfunction

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            step_q     <= 4'd0;
            write_q    <= 1'b0;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            err_q      <= 1'b0;
            rdata_q    <= 8'h00;
            captured_q <= 1'b0;
            wait_cnt_q <= 8'h00;
            gap_cnt_q  <= 16'h0000;
            cmd_q      <= CMD_IDLE;
            dat_q      <= 8'h00;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            captured_q <= captured_d;
            wait_cnt_q <= wait_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            cmd_q      <= cmd_d;
            dat_q      <= dat_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        captured_d = captured_q;
        wait_cnt_d = wait_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        cmd_d      = cmd_q;
        dat_d      = dat_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    write_d    = req_write;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    step_d     = 4'd0;
                    err_d      = 1'b0;
                    rdata_d    = 8'h00;
                    captured_d = 1'b0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_cnt_d = 8'h00;
                state_d    = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (sccb_busy) begin
                    state_d = S_WAIT_LO;
                end else if (wait_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_WAIT_LO: begin
                if (!sccb_busy) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (cmd_q == CMD_STOP) begin
                    gap_cnt_d = GAP_LOAD;
                    state_d   = S_GAP;
                end else begin
                    step_d  = step_q + 4'd1;
                    state_d = S_ISSUE;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 16'h0000) begin
                    if (!write_q && step_q == RD_MID_STOP) begin
                        step_d  = RD_RESTART;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            S_DONE: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Only the first data pulse of the READ step is kept.
        if (!write_q && step_q == RD_READ_STEP && !captured_q && sccb_out_flag &&
            (state_q inside {S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_NEXT})) begin
            rdata_d    = sccb_out_dat;
            captured_d = 1'b1;
        end

        if (state_d == S_ISSUE) begin
            {cmd_d, dat_d} = step_word(write_d, step_d, addr_d, wdata_d);
        end

        ready_d = (state_d == S_IDLE);
    end

    assign req_ready = ready_q;
    assign sccb_flag = (state_q == S_ISSUE);
    assign sccb_cmd  = cmd_q;
    assign sccb_dat  = dat_q;
    assign rsp_valid = (state_q == S_DONE);
    assign rsp_err   = (state_q == S_DONE) && err_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sccb_reg_sequencer.sv
// Bench for sccb_reg_sequencer: a behavioural sccb_controller model plus a
// program/timing reference built from the register transaction rules.
module tb_sccb_reg_sequencer;

    localparam logic [7:0] DEV = 8'h42;
    localparam int GAP = 16;
    localparam int BTO = 15;
    localparam logic [3:0] C_START = 4'b0001, C_WRITE = 4'b0010, C_READ = 4'b0011, C_STOP = 4'b0110;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0, req_write = 1'b0;
    logic [7:0] req_addr = 8'h00, req_wdata = 8'h00;
    logic       req_ready, rsp_valid, rsp_err, sccb_flag;
    logic [7:0] rsp_rdata, sccb_dat;
    logic [3:0] sccb_cmd;
    logic       sccb_busy, sccb_out_flag;
    logic [7:0] sccb_out_dat;

    sccb_reg_sequencer #(.DEV_ID(DEV), .GAP_CYCLES(GAP), .BUSY_TO(BTO)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .sccb_flag(sccb_flag), .sccb_cmd(sccb_cmd), .sccb_dat(sccb_dat),
        .sccb_busy(sccb_busy), .sccb_out_dat(sccb_out_dat), .sccb_out_flag(sccb_out_flag)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0] cmd;
        logic [7:0] dat;
        int         cyc;
        int         rel;   // cycle the controller released the command
    } strobe_t;

    strobe_t    strb_q[$];
    logic [15:0] mute_mask = 16'h0000;
    int         busy_len_fixed = 0;
    logic       rd_dup = 1'b0;
    logic [7:0] rd_d1 = 8'h00, rd_d2 = 8'h00;
    logic       seen_rd = 1'b0;
    logic [7:0] seen_rdata = 8'h00;
    logic       model_busy = 1'b0;

    // Controller model: reacts to each strobe with a busy window, or stays silent if muted.
    initial begin : ctrl_model
        strobe_t s;
        int idx, d, len;
        sccb_busy = 1'b0;
        sccb_out_flag = 1'b0;
        sccb_out_dat = 8'h00;
        forever begin
            @(negedge sys_clk);
            if (sccb_flag === 1'b1) begin
                s.cmd = sccb_cmd;
                s.dat = sccb_dat;
                s.cyc = cyc;
                s.rel = cyc + BTO;
                idx = strb_q.size();
                strb_q.push_back(s);
                if (!(idx < 16 && mute_mask[idx])) begin
                    model_busy = 1'b1;
                    d = $urandom_range(1, 3);
                    repeat (d) @(negedge sys_clk);
                    sccb_busy = 1'b1;
                    len = (busy_len_fixed > 0) ? busy_len_fixed : $urandom_range(4, 20);
                    for (int k = 0; k < len; k++) begin
                        sccb_out_flag = 1'b0;
                        if (s.cmd == C_READ && (k == 1 || (rd_dup && k == 3))) begin
                            sccb_out_flag = 1'b1;
                            sccb_out_dat = (k == 1) ? rd_d1 : rd_d2;
                            if (!seen_rd) begin
                                seen_rd = 1'b1;
                                seen_rdata = sccb_out_dat;
                            end
                        end
                        @(negedge sys_clk);
                    end
                    sccb_out_flag = 1'b0;
                    sccb_busy = 1'b0;
                    strb_q[idx].rel = cyc;
                    model_busy = 1'b0;
                end
            end
        end
    end

    logic [3:0] exp_cmd[$];
    logic [7:0] exp_dat[$];
    logic       cur_wr;

    task automatic push_step(input logic [3:0] c, input logic [7:0] v);
        exp_cmd.push_back(c);
        exp_dat.push_back(v);
    endtask

    task automatic build_prog(input logic wr, input logic [7:0] a, input logic [7:0] w);
        exp_cmd.delete();
        exp_dat.delete();
        push_step(C_START, 8'h00);
        push_step(C_WRITE, DEV);
        push_step(C_WRITE, a);
        if (wr) begin
            push_step(C_WRITE, w);
            push_step(C_STOP, 8'h00);
        end else begin
            push_step(C_STOP, 8'h00);
            push_step(C_START, 8'h00);
            push_step(C_WRITE, DEV | 8'h01);
            push_step(C_READ, 8'h00);
            push_step(C_STOP, 8'h00);
        end
    endtask

    task automatic start_req(input logic wr, input logic [7:0] a, input logic [7:0] w,
                             input logic hold, output int acc);
        int n;
        n = 0;
        while (model_busy && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        strb_q.delete();
        seen_rd = 1'b0;
        cur_wr = wr;
        build_prog(wr, a, w);
        req_write = wr;
        req_addr = a;
        req_wdata = w;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 3000) begin
            @(negedge sys_clk);
            n++;
        end
        check_eq("accept_ready", req_ready, 1'b1);
        acc = cyc;
        @(negedge sys_clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic finish_req(input int acc, output int done_cyc);
        int n, ec;
        logic exp_err;
        logic [7:0] exp_rd;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 4000) begin
            @(negedge sys_clk);
            n++;
        end
        check_eq("rsp_seen", rsp_valid, 1'b1);
        done_cyc = cyc;
        exp_err = 1'b0;
        for (int i = 0; i < exp_cmd.size(); i++) if (mute_mask[i]) exp_err = 1'b1;
        exp_rd = (!cur_wr && seen_rd) ? seen_rdata : 8'h00;
        check_eq("rsp_err", rsp_err, exp_err);
        check_eq("rsp_rdata", rsp_rdata, exp_rd);
        check_eq("ready_low_at_rsp", req_ready, 1'b0);
        check_eq("strobe_count", strb_q.size(), exp_cmd.size());
        if (strb_q.size() == exp_cmd.size()) begin
            for (int i = 0; i < exp_cmd.size(); i++) begin
                check_eq($sformatf("cmd[%0d]", i), strb_q[i].cmd, exp_cmd[i]);
                if (exp_cmd[i] == C_WRITE) check_eq($sformatf("dat[%0d]", i), strb_q[i].dat, exp_dat[i]);
                if (i == 0) ec = acc + 1;
                else ec = strb_q[i-1].rel + 2 + ((exp_cmd[i-1] == C_STOP) ? GAP : 0);
                check_eq($sformatf("strobe_cyc[%0d]", i), strb_q[i].cyc, ec);
            end
            ec = strb_q[strb_q.size()-1].rel + 2 + GAP;
            check_eq("rsp_cyc", done_cyc, ec);
        end
        $display("txn %s addr/strobes=%0d err=%0b rdata=%02h at cyc %0d",
                 cur_wr ? "WR" : "RD", strb_q.size(), rsp_err, rsp_rdata, done_cyc);
        @(negedge sys_clk);
        check_eq("rsp_one_cycle", rsp_valid, 1'b0);
        check_eq("ready_after_rsp", req_ready, 1'b1);
    endtask

    task automatic run_txn(input logic wr, input logic [7:0] a, input logic [7:0] w);
        int acc, dc;
        start_req(wr, a, w, 1'b0, acc);
        finish_req(acc, dc);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int acc, acc2, dc, dc2, n;
        logic wr;
        // Reset state
        repeat (3) @(negedge sys_clk);
        check_eq("rst_ready", req_ready, 1'b0);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_rsp_err", rsp_err, 1'b0);
        check_eq("rst_flag", sccb_flag, 1'b0);
        check_eq("rst_cmd", sccb_cmd, 4'b0000);
        check_eq("rst_dat", sccb_dat, 8'h00);
        check_eq("rst_rdata", rsp_rdata, 8'h00);
        rst = 1'b1;
        #1 check_eq("ready_before_edge", req_ready, 1'b0);
        @(negedge sys_clk);
        check_eq("ready_first_edge", req_ready, 1'b1);

        // Directed write, 20-cycle busy
        busy_len_fixed = 20;
        run_txn(1'b1, 8'h12, 8'h80);
        busy_len_fixed = 0;

        // Directed read returning 76
        rd_d1 = 8'h76; rd_dup = 1'b0;
        run_txn(1'b0, 8'h0A, 8'h00);

        // Timeout on the second step
        mute_mask = 16'h0002;
        run_txn(1'b1, 8'h34, 8'h56);
        // Timeout on the READ step: no data captured
        mute_mask = 16'h0040;
        run_txn(1'b0, 8'h21, 8'h00);
        mute_mask = 16'h0000;

        // Duplicate read-data pulses
        rd_d1 = 8'h55; rd_d2 = 8'hAA; rd_dup = 1'b1;
        run_txn(1'b0, 8'h1C, 8'h00);
        rd_dup = 1'b0;

        // Back-to-back writes with req_valid held
        start_req(1'b1, 8'h40, 8'h01, 1'b1, acc);
        finish_req(acc, dc);
        start_req(1'b1, 8'h41, 8'h02, 1'b0, acc2);
        check_eq("b2b_accept_cyc", acc2, dc + 1);
        finish_req(acc2, dc2);

        // Reset during WAIT_LO of a read
        start_req(1'b0, 8'h0B, 8'h00, 1'b0, acc);
        n = 0;
        while (!(strb_q.size() >= 3 && sccb_busy === 1'b1) && n < 500) begin
            @(negedge sys_clk);
            n++;
        end
        @(negedge sys_clk);
        check_eq("reach_wait_lo", sccb_busy, 1'b1);
        #2 rst = 1'b0;
        req_valid = 1'b0;
        #1;
        check_eq("mid_rst_ready", req_ready, 1'b0);
        check_eq("mid_rst_flag", sccb_flag, 1'b0);
        check_eq("mid_rst_cmd", sccb_cmd, 4'b0000);
        check_eq("mid_rst_dat", sccb_dat, 8'h00);
        check_eq("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("mid_rst_rsp_err", rsp_err, 1'b0);
        check_eq("mid_rst_rdata", rsp_rdata, 8'h00);
        n = 0;
        while (model_busy && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        check_eq("ready_after_mid_rst", req_ready, 1'b1);
        run_txn(1'b1, 8'h3A, 8'hC3);

        // Randomized transactions
        for (int t = 0; t < 30; t++) begin
            wr = $urandom_range(0, 1);
            mute_mask = 16'h0000;
            for (int b = 0; b < 9; b++) if ($urandom_range(0, 9) == 0) mute_mask[b] = 1'b1;
            rd_dup = $urandom_range(0, 1);
            rd_d1 = 8'($urandom);
            rd_d2 = 8'($urandom);
            run_txn(wr, 8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge sys_clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
